// File: rtl/pipeline_stall_controller.sv
// IF/ID stall/flush responder: owns the IF/ID register, drives PC write-enable and ID/EX bubble.
// Optional performance counters are enabled by defining PERF_COUNTERS_EN.
//
// state | meaning
// RUN   | pipeline advancing normally
// STALL | IF/ID held, bubble inserted into ID/EX
// FLUSH | IF/ID squashed by a taken branch/jump (one cycle per flush_req)
module pipeline_stall_controller #(
  parameter int          XLEN      = 32,
  parameter int          MAX_STALL = 4,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             if_valid,
  output logic             pc_write_en,
  output logic [XLEN-1:0]  if_id_instr,
  output logic [XLEN-1:0]  if_id_pc,
  output logic             if_id_valid,
  output logic             id_ex_bubble,
  output logic [1:0]       ctrl_state,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int RL_W = $clog2(MAX_STALL + 1);
  localparam logic [RL_W-1:0] RL_LOAD = RL_W'(MAX_STALL);
  localparam logic [RL_W-1:0] RL_ONE  = RL_W'(1);
  localparam logic [XLEN-1:0] NOP     = XLEN'(NOP_INSTR);

  state_t          state;
  logic [RL_W-1:0] run_left;
  logic            stall_eff;

  // A taken branch wins: the stalled instruction is squashed anyway.
  assign stall_eff    = stall_req & ~flush_req;
  assign pc_write_en  = ~stall_eff;
  assign id_ex_bubble = stall_eff | flush_req;
  assign ctrl_state   = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      if_id_instr   <= NOP;
      if_id_pc      <= '0;
      if_id_valid   <= 1'b0;
      run_left      <= RL_LOAD;
      stall_timeout <= 1'b0;
    end else begin
      if (flush_req) begin
        if_id_instr <= NOP;
        if_id_valid <= 1'b0;
      end else if (!stall_eff) begin
        if_id_instr <= if_valid ? if_instr : NOP;
        if_id_pc    <= if_pc;
        if_id_valid <= if_valid;
      end

      if (flush_req)      state <= FLUSH;
      else if (stall_eff) state <= STALL;
      else                state <= RUN;

      // Down-counter of remaining tolerated stall cycles; terminal count flags the timeout.
      if (stall_eff) begin
        if (run_left != '0) begin
          run_left <= run_left - RL_ONE;
          if (run_left == RL_ONE) stall_timeout <= 1'b1;
        end
      end else begin
        run_left <= RL_LOAD;
      end
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_eff && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_req && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; counter expectations follow PERF_COUNTERS_EN.
module tb_pipeline_stall_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_req;
  logic        flush_req;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        pc_write_en;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        id_ex_bubble;
  logic [1:0]  ctrl_state;
  logic        stall_timeout;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_req     (stall_req),
    .flush_req     (flush_req),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .pc_write_en   (pc_write_en),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .id_ex_bubble  (id_ex_bubble),
    .ctrl_state    (ctrl_state),
    .stall_timeout (stall_timeout),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int n);
`ifdef PERF_COUNTERS_EN
    return 32'(n);
`else
    return (n == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_req = 1'b0; flush_req = 1'b0;
    if_valid = 1'b0; if_instr = '0; if_pc = '0;
    tick(); tick();
    check("rst_instr",   if_id_instr, 32'h00000013);
    check("rst_pc",      if_id_pc, 32'h0);
    check("rst_valid",   32'(if_id_valid), 32'd0);
    check("rst_state",   32'(ctrl_state), 32'd0);
    check("rst_tmo",     32'(stall_timeout), 32'd0);
    check("rst_scnt",    32'(stall_count), 32'd0);
    check("rst_fcnt",    32'(flush_count), 32'd0);
    check("rst_pcwe",    32'(pc_write_en), 32'd1);
    check("rst_bubble",  32'(id_ex_bubble), 32'd0);

    rst_n = 1'b1; if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h100;
    tick();
    check("run_instr",  if_id_instr, 32'h00500093);
    check("run_pc",     if_id_pc, 32'h100);
    check("run_valid",  32'(if_id_valid), 32'd1);
    check("run_pcwe",   32'(pc_write_en), 32'd1);
    check("run_bubble", 32'(id_ex_bubble), 32'd0);
    check("run_state",  32'(ctrl_state), 32'd0);

    // two-cycle stall while fetch moves on
    stall_req = 1'b1; if_pc = 32'h104; if_instr = 32'h00600113;
    #1;
    check("st1_pcwe",   32'(pc_write_en), 32'd0);
    check("st1_bubble", 32'(id_ex_bubble), 32'd1);
    tick();
    check("st1_pc",     if_id_pc, 32'h100);
    check("st1_instr",  if_id_instr, 32'h00500093);
    check("st1_state",  32'(ctrl_state), 32'd1);
    check("st2_pcwe",   32'(pc_write_en), 32'd0);
    check("st2_bubble", 32'(id_ex_bubble), 32'd1);
    tick();
    check("st2_pc",     if_id_pc, 32'h100);
    check("st2_state",  32'(ctrl_state), 32'd1);
    check("st2_scnt",   32'(stall_count), cnt(2));
    stall_req = 1'b0;
    tick();
    check("st3_pc",     if_id_pc, 32'h104);
    check("st3_instr",  if_id_instr, 32'h00600113);
    check("st3_state",  32'(ctrl_state), 32'd0);

    // flush wins over stall
    stall_req = 1'b1; flush_req = 1'b1;
    #1;
    check("fl_pcwe",    32'(pc_write_en), 32'd1);
    check("fl_bubble",  32'(id_ex_bubble), 32'd1);
    tick();
    check("fl_instr",   if_id_instr, 32'h00000013);
    check("fl_valid",   32'(if_id_valid), 32'd0);
    check("fl_pc",      if_id_pc, 32'h104);
    check("fl_state",   32'(ctrl_state), 32'd2);
    check("fl_fcnt",    32'(flush_count), cnt(1));
    check("fl_scnt",    32'(stall_count), cnt(2));
    stall_req = 1'b0; flush_req = 1'b0;
    tick();
    check("fl_back",    32'(ctrl_state), 32'd0);
    check("fl_reload",  32'(if_id_valid), 32'd1);

    // back-to-back flushes, then FLUSH -> STALL
    flush_req = 1'b1;
    tick();
    check("bb1_state",  32'(ctrl_state), 32'd2);
    tick();
    check("bb2_state",  32'(ctrl_state), 32'd2);
    check("bb2_fcnt",   32'(flush_count), cnt(3));
    check("bb2_valid",  32'(if_id_valid), 32'd0);
    flush_req = 1'b0; stall_req = 1'b1;
    tick();
    check("fs_state",   32'(ctrl_state), 32'd1);
    check("fs_scnt",    32'(stall_count), cnt(3));
    stall_req = 1'b0; if_valid = 1'b0; if_pc = 32'h108;
    tick();
    check("iv_state",   32'(ctrl_state), 32'd0);
    check("iv_valid",   32'(if_id_valid), 32'd0);
    check("iv_instr",   if_id_instr, 32'h00000013);
    check("iv_pc",      if_id_pc, 32'h108);

    // five-cycle stall: timeout only at the 4th stalled edge
    if_valid = 1'b1; stall_req = 1'b1;
    tick(); tick(); tick();
    check("to3_tmo",    32'(stall_timeout), 32'd0);
    tick();
    check("to4_tmo",    32'(stall_timeout), 32'd1);
    tick();
    check("to5_tmo",    32'(stall_timeout), 32'd1);
    check("to5_state",  32'(ctrl_state), 32'd1);
    check("to5_scnt",   32'(stall_count), cnt(8));
    stall_req = 1'b0;
    tick();
    check("to_sticky",  32'(stall_timeout), 32'd1);
    check("to_state",   32'(ctrl_state), 32'd0);

    // reset in the middle of a stall
    stall_req = 1'b1;
    tick(); tick();
    check("ms_scnt",    32'(stall_count), cnt(10));
    rst_n = 1'b0;
    #1;
    check("ms_pcwe",    32'(pc_write_en), 32'd0);
    tick();
    check("ms_state",   32'(ctrl_state), 32'd0);
    check("ms_valid",   32'(if_id_valid), 32'd0);
    check("ms_tmo",     32'(stall_timeout), 32'd0);
    check("ms_scnt0",   32'(stall_count), 32'd0);
    check("ms_fcnt0",   32'(flush_count), 32'd0);
    check("ms_instr",   if_id_instr, 32'h00000013);
    rst_n = 1'b1; stall_req = 1'b0;
    #1;
    check("ms_bubble",  32'(id_ex_bubble), 32'd0);
    tick();
    check("ms_run",     32'(ctrl_state), 32'd0);
    check("ms_pc",      if_id_pc, 32'h108);
    check("ms_valid1",  32'(if_id_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
